// File: rtl/sdp_core_split_pkg.sv
// sdp_core_split_pkg: shared constants, FSM state type and helper functions
// for the SDP wide-to-narrow splitter.
package sdp_core_split_pkg;

  localparam int SPLIT_CNT_W     = 4;
  localparam int SPLIT_MAX_RATIO = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } split_state_e;

  // Only power-of-two ratios that fit the 4-bit segment counter are supported.
  function automatic logic split_ratio_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) ||
           (ratio == 8) || (ratio == 16);
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SPLIT_CNT_W-1:0] split_lowest_set(
    input logic [SPLIT_MAX_RATIO-1:0] mask
  );
    logic [SPLIT_CNT_W-1:0] idx;
    idx = '0;
    for (int i = SPLIT_MAX_RATIO - 1; i >= 0; i--) begin
      if (mask[i]) idx = SPLIT_CNT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdp_core_split_if.sv
// sdp_core_split_if: wide input / narrow output handshake bundle.
// inp_mask exists only when SDP_CORE_SPLIT_MASK_EN is defined.
// master = upstream producer + downstream consumer side, slave = splitter.
interface sdp_core_split_if #(
  parameter int IW = 512,
  parameter int OW = 128
);

  logic          inp_pvld;
  logic          inp_prdy;
  logic [IW-1:0] inp_data;
`ifdef SDP_CORE_SPLIT_MASK_EN
  logic [IW/OW-1:0] inp_mask;
`endif
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_last;

  modport master (
`ifdef SDP_CORE_SPLIT_MASK_EN
    output inp_mask,
`endif
    output inp_pvld, inp_data, out_prdy,
    input  inp_prdy, out_pvld, out_data, out_last
  );

  modport slave (
`ifdef SDP_CORE_SPLIT_MASK_EN
    input  inp_mask,
`endif
    input  inp_pvld, inp_data, out_prdy,
    output inp_prdy, out_pvld, out_data, out_last
  );

endinterface

// File: rtl/sdp_core_split_penc.sv
// sdp_core_split_penc: RATIO-wide priority encoder. Returns the lowest set
// mask index strictly above start, and none_above when there is none.
// Used only when SDP_CORE_SPLIT_MASK_EN is defined.
module sdp_core_split_penc
  import sdp_core_split_pkg::*;
#(
  parameter int RATIO = 4
) (
  input  logic [RATIO-1:0]       mask,
  input  logic [SPLIT_CNT_W-1:0] start,
  output logic [SPLIT_CNT_W-1:0] nxt,
  output logic                   none_above
);

  // Scan high to low so the last hit is the lowest index above start.
  always_comb begin
    nxt        = start;
    none_above = 1'b1;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(start))) begin
        nxt        = SPLIT_CNT_W'(i);
        none_above = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdp_core_split.sv
// sdp_core_split: accepts one IW-bit word and replays it as RATIO OW-bit
// segments, lowest first, with no bubble between consecutive words.
// Optional macro SDP_CORE_SPLIT_MASK_EN adds a per-segment emit mask.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | nothing held; inp_prdy=1, out_pvld=0
//   ST_HOLD  | word held; out_data shows segment seg_cnt, out_pvld=1
module sdp_core_split
  import sdp_core_split_pkg::*;
#(
  parameter int IW    = 512,
  parameter int OW    = 128,
  parameter int RATIO = IW / OW
) (
  input logic             nvdla_core_clk,
  input logic             nvdla_core_rstn,
  sdp_core_split_if.slave bus
);

  if (!split_ratio_legal(RATIO) || (RATIO * OW != IW)) begin : g_bad_ratio
    $error("sdp_core_split: illegal RATIO %0d (IW=%0d OW=%0d)", RATIO, IW, OW);
  end

  split_state_e           state_q;
  split_state_e           state_d;
  logic [IW-1:0]          hold_data;
  logic [SPLIT_CNT_W-1:0] seg_cnt;
  logic [SPLIT_CNT_W-1:0] load_cnt;
  logic [SPLIT_CNT_W-1:0] next_cnt;
  logic                   hold_vld;
  logic                   is_last;
  logic                   word_has_seg;
  logic                   inp_acc;
  logic                   out_acc;
  logic                   load;
  logic                   advance;
  logic                   rewind;

  assign hold_vld = (state_q == ST_HOLD);
  assign inp_acc  = bus.inp_pvld & bus.inp_prdy;
  assign out_acc  = hold_vld & bus.out_prdy;

`ifdef SDP_CORE_SPLIT_MASK_EN
  logic [RATIO-1:0]       hold_mask;
  logic [SPLIT_CNT_W-1:0] penc_nxt;
  logic                   penc_none;

  sdp_core_split_penc #(.RATIO(RATIO)) u_penc (
    .mask       (hold_mask),
    .start      (seg_cnt),
    .nxt        (penc_nxt),
    .none_above (penc_none)
  );

  // An all-zero mask consumes the word without producing any segment.
  assign is_last      = penc_none;
  assign word_has_seg = |bus.inp_mask;
  assign load_cnt     = split_lowest_set(SPLIT_MAX_RATIO'(bus.inp_mask));
  assign next_cnt     = penc_nxt;

  // Capture the emit mask alongside the data word.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      hold_mask <= '0;
    end else if (load) begin
      hold_mask <= bus.inp_mask;
    end
  end
`else
  assign is_last      = (seg_cnt == SPLIT_CNT_W'(RATIO - 1));
  assign word_has_seg = 1'b1;
  assign load_cnt     = '0;
  assign next_cnt     = seg_cnt + SPLIT_CNT_W'(1);
`endif

  // State register.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; a last-segment accept may reload in
  // the same cycle, which is what keeps the stream bubble-free.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    rewind  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (inp_acc) begin
          load    = 1'b1;
          state_d = word_has_seg ? ST_HOLD : ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (out_acc) begin
          if (!is_last) begin
            advance = 1'b1;
          end else if (inp_acc) begin
            load    = 1'b1;
            state_d = word_has_seg ? ST_HOLD : ST_EMPTY;
          end else begin
            rewind  = 1'b1;
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs; inp_prdy is the only input-to-output path.
  always_comb begin
    bus.out_pvld = hold_vld;
    bus.out_last = hold_vld & is_last;
    bus.inp_prdy = !hold_vld | (bus.out_prdy & is_last);
  end

  // Holding register and segment counter.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      hold_data <= '0;
      seg_cnt   <= '0;
    end else if (load) begin
      hold_data <= bus.inp_data;
      seg_cnt   <= load_cnt;
    end else if (advance) begin
      seg_cnt   <= next_cnt;
    end else if (rewind) begin
      seg_cnt   <= '0;
    end
  end

  if (RATIO == 1) begin : g_one
    assign bus.out_data = hold_data;
  end else begin : g_mux
    localparam int IDX_W = $clog2(RATIO);
    logic [OW-1:0] seg_arr [RATIO];
    for (genvar k = 0; k < RATIO; k++) begin : g_seg
      assign seg_arr[k] = hold_data[k*OW +: OW];
    end
    assign bus.out_data = seg_arr[seg_cnt[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_sdp_core_split.sv
// tb_sdp_core_split: scoreboard bench for sdp_core_split (RATIO=4 and RATIO=1
// instances). Mask cases are exercised when SDP_CORE_SPLIT_MASK_EN is defined.
module tb_sdp_core_split;
  import sdp_core_split_pkg::*;

  localparam int IW    = 512;
  localparam int OW    = 128;
  localparam int RATIO = IW / OW;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  logic nvdla_core_clk  = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   beat_cyc0[$];
  int   beat_cyc1[$];

  always #5 nvdla_core_clk = ~nvdla_core_clk;
  always @(posedge nvdla_core_clk) cyc <= cyc + 1;

  sdp_core_split_if #(.IW(IW), .OW(OW)) bus0 ();
  sdp_core_split_if #(.IW(OW), .OW(OW)) bus1 ();

  sdp_core_split #(.IW(IW), .OW(OW)) u_dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .bus             (bus0)
  );

  sdp_core_split #(.IW(OW), .OW(OW)) u_dut_r1 (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .bus             (bus1)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    return {{16{b3}}, {16{b2}}, {16{b1}}, {16{b0}}};
  endfunction

  function automatic logic [OW-1:0] seg_of(input logic [IW-1:0] d, input int k);
    return d[k*OW +: OW];
  endfunction

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  // Expected segments of one accepted word: mask bits set, ascending,
  // last flag on the highest one.
  task automatic push_exp0(input logic [IW-1:0] d, input logic [RATIO-1:0] m);
    logic [RATIO-1:0] m_eff;
    exp_t e;
    int hi;
    m_eff = m;
`ifndef SDP_CORE_SPLIT_MASK_EN
    m_eff = '1;
`endif
    hi = -1;
    for (int k = 0; k < RATIO; k++) if (m_eff[k]) hi = k;
    for (int k = 0; k < RATIO; k++) begin
      if (m_eff[k]) begin
        e.data = seg_of(d, k);
        e.last = (k == hi);
        q0.push_back(e);
      end
    end
  endtask

  // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
  task automatic send0(input logic [IW-1:0] d, input logic [RATIO-1:0] m,
                       input bit keep, output int waits);
    bus0.inp_pvld = 1'b1;
    bus0.inp_data = d;
`ifdef SDP_CORE_SPLIT_MASK_EN
    bus0.inp_mask = m;
`endif
    waits = 0;
    @(negedge nvdla_core_clk);
    while (!bus0.inp_prdy && waits < 100) begin
      waits++;
      @(negedge nvdla_core_clk);
    end
    if (!bus0.inp_prdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send0_timeout: got inp_prdy 0 expected 1 within 100 cycles");
    end else begin
      push_exp0(d, m);
    end
    tick();
    if (!keep) bus0.inp_pvld = 1'b0;
    bus0.inp_data = ~d;
  endtask

  task automatic send1(input logic [OW-1:0] d, input bit keep,
                       output int waits, output int acc_cyc);
    exp_t e;
    bus1.inp_pvld = 1'b1;
    bus1.inp_data = d;
`ifdef SDP_CORE_SPLIT_MASK_EN
    bus1.inp_mask = 1'b1;
`endif
    waits   = 0;
    acc_cyc = 0;
    @(negedge nvdla_core_clk);
    while (!bus1.inp_prdy && waits < 100) begin
      waits++;
      @(negedge nvdla_core_clk);
    end
    if (!bus1.inp_prdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send1_timeout: got inp_prdy 0 expected 1 within 100 cycles");
    end else begin
      acc_cyc = cyc;
      e.data  = d;
      e.last  = 1'b1;
      q1.push_back(e);
    end
    tick();
    if (!keep) bus1.inp_pvld = 1'b0;
    bus1.inp_data = ~d;
  endtask

  task automatic drain0(input string name);
    int t;
    t = 0;
    while (q0.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk_int(name, q0.size(), 0);
  endtask

  task automatic drain1(input string name);
    int t;
    t = 0;
    while (q1.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk_int(name, q1.size(), 0);
  endtask

  // Monitor for the RATIO=4 instance: pops on every accepted segment and
  // checks that a stalled segment is held unchanged.
  initial begin : mon0
    logic [OW-1:0] st_data;
    bit stalled;
    exp_t e;
    stalled = 1'b0;
    st_data = '0;
    forever begin
      @(negedge nvdla_core_clk);
      if (nvdla_core_rstn) begin
        if (stalled) begin
          chk_bit("dut0_stall_keep_vld", bus0.out_pvld, 1'b1);
          chk_val("dut0_stall_keep_data", bus0.out_data, st_data);
        end
        stalled = 1'b0;
        if (bus0.out_pvld) begin
          if (bus0.out_prdy) begin
            if (q0.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL dut0_unexpected_beat: got %0h expected no beat", bus0.out_data);
            end else begin
              e = q0.pop_front();
              chk_val("dut0_seg_data", bus0.out_data, e.data);
              chk_bit("dut0_seg_last", bus0.out_last, e.last);
              beat_cyc0.push_back(cyc);
            end
          end else begin
            stalled = 1'b1;
            st_data = bus0.out_data;
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge nvdla_core_clk);
      if (nvdla_core_rstn && bus1.out_pvld && bus1.out_prdy) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut1_unexpected_beat: got %0h expected no beat", bus1.out_data);
        end else begin
          e = q1.pop_front();
          chk_val("dut1_seg_data", bus1.out_data, e.data);
          chk_bit("dut1_seg_last", bus1.out_last, e.last);
          beat_cyc1.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;
    int a0;
    int a1;
    int a2;
    logic [IW-1:0] wa;
    logic [IW-1:0] wb;
    logic [IW-1:0] wc;

    bus0.inp_pvld = 1'b0;
    bus0.inp_data = '0;
    bus0.out_prdy = 1'b1;
    bus1.inp_pvld = 1'b0;
    bus1.inp_data = '0;
    bus1.out_prdy = 1'b1;
`ifdef SDP_CORE_SPLIT_MASK_EN
    bus0.inp_mask = '1;
    bus1.inp_mask = '1;
`endif
    nvdla_core_rstn = 1'b0;
    repeat (3) @(posedge nvdla_core_clk);
    #1;

    // Reset state
    @(negedge nvdla_core_clk);
    chk_bit("rst_out_pvld", bus0.out_pvld, 1'b0);
    chk_bit("rst_out_last", bus0.out_last, 1'b0);
    chk_val("rst_out_data", bus0.out_data, '0);
    chk_bit("rst_inp_prdy", bus0.inp_prdy, 1'b1);
    chk_bit("rst_r1_out_pvld", bus1.out_pvld, 1'b0);
    chk_bit("rst_r1_inp_prdy", bus1.inp_prdy, 1'b1);
    tick();
    nvdla_core_rstn = 1'b1;
    tick();

    // Single word, latency 1
    wa = mk_word(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge nvdla_core_clk);
    chk_bit("t1_idle_pvld", bus0.out_pvld, 1'b0);
    tick();
    send0(wa, '1, 1'b0, w);
    chk_int("t1_waits", w, 0);
    @(negedge nvdla_core_clk);
    chk_bit("t1_latency_pvld", bus0.out_pvld, 1'b1);
    chk_val("t1_first_seg", bus0.out_data, seg_of(wa, 0));
    tick();
    drain0("t1_drain");
    @(negedge nvdla_core_clk);
    chk_bit("t1_idle_after", bus0.out_pvld, 1'b0);
    tick();

    // Three back-to-back words: inp_prdy returns only on each 4th segment
    beat_cyc0.delete();
    send0(mk_word(8'h01, 8'h02, 8'h03, 8'h04), '1, 1'b1, w);
    chk_int("t2_w0_waits", w, 0);
    send0(mk_word(8'h05, 8'h06, 8'h07, 8'h08), '1, 1'b1, w);
    chk_int("t2_w1_waits", w, 3);
    send0(mk_word(8'h09, 8'h0a, 8'h0b, 8'h0c), '1, 1'b0, w);
    chk_int("t2_w2_waits", w, 3);
    drain0("t2_drain");
    chk_int("t2_beats", beat_cyc0.size(), 12);
    if (beat_cyc0.size() == 12) chk_int("t2_gapless_span", beat_cyc0[11] - beat_cyc0[0], 11);

    // Stall on segment 2: out_prdy 1 (seg1), 0, 0, 1 (seg2)
    wb = mk_word(8'ha1, 8'hb2, 8'hc3, 8'hd4);
    send0(wb, '1, 1'b0, w);
    tick();
    tick();
    bus0.out_prdy = 1'b0;
    @(negedge nvdla_core_clk);
    chk_val("t3_stall_data_a", bus0.out_data, seg_of(wb, 2));
    chk_bit("t3_stall_prdy_a", bus0.inp_prdy, 1'b0);
    tick();
    @(negedge nvdla_core_clk);
    chk_val("t3_stall_data_b", bus0.out_data, seg_of(wb, 2));
    chk_bit("t3_stall_prdy_b", bus0.inp_prdy, 1'b0);
    tick();
    bus0.out_prdy = 1'b1;
    @(negedge nvdla_core_clk);
    chk_val("t3_release_data", bus0.out_data, seg_of(wb, 2));
    tick();
    drain0("t3_drain");

    // Reset after two of four segments accepted
    wc = mk_word(8'h5a, 8'h6b, 8'h7c, 8'h8d);
    send0(wc, '1, 1'b0, w);
    tick();
    tick();
    nvdla_core_rstn = 1'b0;
    bus0.out_prdy   = 1'b0;
    q0.delete();
    tick();
    @(negedge nvdla_core_clk);
    chk_bit("t4_rst_pvld", bus0.out_pvld, 1'b0);
    chk_bit("t4_rst_prdy", bus0.inp_prdy, 1'b1);
    chk_bit("t4_rst_last", bus0.out_last, 1'b0);
    tick();
    nvdla_core_rstn = 1'b1;
    bus0.out_prdy   = 1'b1;
    tick();
    wc = mk_word(8'he1, 8'he2, 8'he3, 8'he4);
    send0(wc, '1, 1'b0, w);
    @(negedge nvdla_core_clk);
    chk_val("t4_restart_seg0", bus0.out_data, seg_of(wc, 0));
    tick();
    drain0("t4_drain");

`ifdef SDP_CORE_SPLIT_MASK_EN
    // Sparse mask and empty mask
    wa = mk_word(8'h31, 8'h32, 8'h33, 8'h34);
    send0(wa, 4'b1010, 1'b0, w);
    @(negedge nvdla_core_clk);
    chk_val("t5_mask_first_seg", bus0.out_data, seg_of(wa, 1));
    chk_bit("t5_mask_first_last", bus0.out_last, 1'b0);
    tick();
    drain0("t5_mask_drain");
    send0(mk_word(8'h41, 8'h42, 8'h43, 8'h44), 4'b0000, 1'b0, w);
    chk_int("t5_zero_mask_waits", w, 0);
    repeat (3) begin
      @(negedge nvdla_core_clk);
      chk_bit("t5_zero_mask_idle", bus0.out_pvld, 1'b0);
      tick();
    end
`endif

    // RATIO=1 register slice at full throughput
    beat_cyc1.delete();
    send1({16{8'h71}}, 1'b1, w, a0);
    chk_int("t6_w0_waits", w, 0);
    send1({16{8'h72}}, 1'b1, w, a1);
    chk_int("t6_w1_waits", w, 0);
    send1({16{8'h73}}, 1'b0, w, a2);
    chk_int("t6_w2_waits", w, 0);
    chk_int("t6_acc_span", a2 - a0, 2);
    drain1("t6_drain");
    chk_int("t6_beats", beat_cyc1.size(), 3);
    if (beat_cyc1.size() == 3) begin
      chk_int("t6_latency", beat_cyc1[0] - a0, 1);
      chk_int("t6_gapless_span", beat_cyc1[2] - beat_cyc1[0], 2);
    end

    tick();
    chk_int("final_q0_empty", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_core_split.md
Name: sdp_core_split

Overview:
- Wide-to-narrow width converter for the SDP datapath. It is the inverse of the SDP core packer.
- Accepts one IW-bit word on a valid/ready input. Emits it as RATIO consecutive OW-bit segments on a valid/ready output, lowest segment first.
- Sits between SDP wide internal buses and narrower DMA/write-path interfaces.
- Sustains full throughput: no bubble between consecutive wide words.

Parameters:
- IW, 512, input (wide) data width in bits.
- OW, 128, output (narrow) segment width in bits.
- RATIO, IW/OW, segments per wide word. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- nvdla_core_clk  input  1  core clock; all logic on the rising edge.
- nvdla_core_rstn  input  1  reset, synchronous, active-low.
- inp_pvld  input  1  wide word valid.
- inp_prdy  output  1  wide word ready.
- inp_data  input  IW  wide word; segment k is bits [k*OW +: OW].
- inp_mask  input  RATIO  per-segment emit mask. Present only with SDP_CORE_SPLIT_MASK_EN.
- out_pvld  output  1  segment valid.
- out_prdy  input  1  segment ready.
- out_data  output  OW  current segment.
- out_last  output  1  current segment is the final one of its wide word.

Behaviour:
- Reset: nvdla_core_rstn is synchronous and active-low. While it is low at a clock edge:
  - hold_vld<=0, seg_cnt<=0, hold_data<=0.
  - Outputs then read out_pvld=0, out_last=0, out_data=0, inp_prdy=1.
- A reset asserted mid-word discards the held word. No further segments of that word are emitted.
- State: a single holding register (hold_data, plus hold_mask in mask mode), a 4-bit seg_cnt and hold_vld. Two states:
  - EMPTY: hold_vld=0.
  - HOLD: hold_vld=1.
- Handshakes:
  - inp_acc = inp_pvld & inp_prdy.
  - out_acc = out_pvld & out_prdy.
  - A transfer occurs only when valid and ready are both high at the edge.
- Combinational outputs:
  - out_pvld = hold_vld.
  - out_data = hold_data[seg_cnt*OW +: OW].
  - out_last = hold_vld & is_last.
  - is_last = (seg_cnt == RATIO-1).
  - inp_prdy = !hold_vld | (out_prdy & is_last).
  - inp_prdy depends combinationally on out_prdy. No other input-to-output path exists.
- EMPTY, inp_acc: load hold_data and set seg_cnt=0 → HOLD. The first segment is visible the next cycle (latency 1).
- HOLD, out_acc & !is_last: seg_cnt increments.
- HOLD, out_acc & is_last & inp_acc: load the new word and set seg_cnt=0; stay in HOLD. This is back-to-back, with zero bubble.
- HOLD, out_acc & is_last & !inp_acc: seg_cnt=0 → EMPTY.
- HOLD, !out_prdy: all state and outputs hold stable.
  - out_pvld never drops without out_acc.
  - out_data never changes without out_acc.
- RATIO=1: every word passes straight through a one-stage register slice, with out_last=1 on every beat.
- Upstream inp_data need not stay stable after inp_acc.

Optional Feature:
- Macro: SDP_CORE_SPLIT_MASK_EN.
- With the macro:
  - inp_mask is captured into hold_mask on inp_acc. Only segments whose mask bit is set are emitted, in ascending index order.
  - On load, seg_cnt = index of the lowest set bit.
  - On out_acc, seg_cnt = next set bit above seg_cnt.
  - is_last = no set bit above seg_cnt.
  - inp_mask == 0: the word is accepted with inp_prdy as normal and dropped. hold_vld stays 0 (or falls to 0 on a back-to-back load), and no output is produced.
- Without the macro:
  - The inp_mask port is absent. All RATIO segments are always emitted.
  - The mask, hold_mask and priority-encoder logic are removed.

Decomposition:
- Package sdp_core_split_pkg holds:
  - SPLIT_CNT_W = 4.
  - SPLIT_MAX_RATIO = 16.
  - The legal-ratio check function.
  - A function returning the lowest set bit index of a mask vector.
- One sub-module, sdp_core_split_penc: a RATIO-wide priority encoder. Given a mask and a start index, it returns the next set index and a "none above" flag. It is instantiated only under SDP_CORE_SPLIT_MASK_EN.

Test Plan:
- IW=512, OW=128, out_prdy=1; send one word with segments 0x11..,0x22..,0x33..,0x44.. → out_pvld rises 1 cycle after inp_acc; segments 0x11,0x22,0x33,0x44 on 4 consecutive cycles; out_last only on 0x44.
- Continuous inp_pvld with 3 words, out_prdy=1 → 12 output beats with no gaps; inp_prdy high only on the cycles where the 4th segment is accepted.
- out_prdy toggled 1,0,0,1 during segment 2 → out_data holds segment 2 through the stall; no segment lost or repeated; inp_prdy stays 0.
- Reset pulse after 2 of 4 segments accepted → out_pvld=0 and inp_prdy=1 the cycle after reset; the next word restarts at segment 0.
- MASK_EN, inp_mask=4'b1010 → only segments 1 then 3 are emitted; out_last on segment 3. inp_mask=4'b0000 → word consumed, no out_pvld.
- RATIO=1 (IW=OW=128) → each word appears 1 cycle later with out_last=1; full throughput under out_prdy=1.
